// File: rtl/fifo_sync_prog.sv
// Single-clock FIFO with arbitrary depth, programmable almost-full and almost-empty
// thresholds, sticky error flags, synchronous flush, and an optional FWFT read port.
module fifo_sync_prog #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2,
  parameter int FWFT       = 0
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic                  flush,
  input  logic                  clr_err,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  f_full,
  output logic                  f_empty,
  output logic                  f_almost_full,
  output logic                  f_almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  f_overflow,
  output logic                  f_underflow
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_C  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   AF_C     = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0]   AE_C     = (ADDR_WIDTH+1)'(AE_LEVEL);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_LAST = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  wr_acc;
  logic                  rd_acc;

  // Flags come only from the registered count, never from wr_en/rd_en.
  assign f_full         = (count == DEPTH_C);
  assign f_empty        = (count == '0);
  assign f_almost_full  = (count >= AF_C);
  assign f_almost_empty = (count <= AE_C);

  assign wr_acc = wr_en && !f_full && !flush;
  assign rd_acc = rd_en && !f_empty && !flush;

  // Wrap by explicit compare, so DEPTH need not be a power of two.
  function automatic logic [ADDR_WIDTH-1:0] next_ptr(input logic [ADDR_WIDTH-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_ONE;
  endfunction

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= next_ptr(wr_ptr);
      if (rd_acc) rd_ptr <= next_ptr(rd_ptr);
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= din;
  end

  // A new error in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      f_overflow  <= 1'b0;
      f_underflow <= 1'b0;
    end else begin
      if (wr_en && f_full && !flush)    f_overflow <= 1'b1;
      else if (clr_err)                 f_overflow <= 1'b0;
      if (rd_en && f_empty && !flush)   f_underflow <= 1'b1;
      else if (clr_err)                 f_underflow <= 1'b0;
    end
  end

  if (FWFT != 0) begin : g_fwft
    assign dout = f_empty ? '0 : mem[rd_ptr];
  end else begin : g_reg
    logic [DATA_WIDTH-1:0] dout_q;

    always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)      dout_q <= '0;
      else if (flush)  dout_q <= '0;
      else if (rd_acc) dout_q <= mem[rd_ptr];
    end

    assign dout = dout_q;
  end

endmodule

// File: tb/tb_fifo_sync_prog.sv
// Directed bench for fifo_sync_prog: depth-16 registered read, depth-12 random
// streaming against a queue model, and a depth-16 first-word-fall-through instance.
module tb_fifo_sync_prog;

  logic clk;
  logic n_rst;

  logic       a_wr, a_rd, a_flush, a_clr;
  logic [7:0] a_din, a_dout;
  logic       a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
  logic [4:0] a_count;

  logic       b_wr, b_rd, b_flush, b_clr;
  logic [7:0] b_din, b_dout;
  logic       b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
  logic [4:0] b_count;

  logic       c_wr, c_rd, c_flush, c_clr;
  logic [7:0] c_din, c_dout;
  logic       c_full, c_empty, c_af, c_ae, c_ovf, c_unf;
  logic [4:0] c_count;

  int n_chk = 0;
  int n_err = 0;

  fifo_sync_prog #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(16), .FWFT(0)) u_a (
    .clk(clk), .n_rst(n_rst), .wr_en(a_wr), .rd_en(a_rd), .flush(a_flush),
    .clr_err(a_clr), .din(a_din), .dout(a_dout), .f_full(a_full), .f_empty(a_empty),
    .f_almost_full(a_af), .f_almost_empty(a_ae), .count(a_count),
    .f_overflow(a_ovf), .f_underflow(a_unf));

  fifo_sync_prog #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(12), .FWFT(0)) u_b (
    .clk(clk), .n_rst(n_rst), .wr_en(b_wr), .rd_en(b_rd), .flush(b_flush),
    .clr_err(b_clr), .din(b_din), .dout(b_dout), .f_full(b_full), .f_empty(b_empty),
    .f_almost_full(b_af), .f_almost_empty(b_ae), .count(b_count),
    .f_overflow(b_ovf), .f_underflow(b_unf));

  fifo_sync_prog #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(16), .FWFT(1)) u_c (
    .clk(clk), .n_rst(n_rst), .wr_en(c_wr), .rd_en(c_rd), .flush(c_flush),
    .clr_err(c_clr), .din(c_din), .dout(c_dout), .f_full(c_full), .f_empty(c_empty),
    .f_almost_full(c_af), .f_almost_empty(c_ae), .count(c_count),
    .f_overflow(c_ovf), .f_underflow(c_unf));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] exp_d;
    logic       exp_wr, exp_rd;
    int         wcount;

    n_rst = 1'b0;
    {a_wr, a_rd, a_flush, a_clr} = '0; a_din = '0;
    {b_wr, b_rd, b_flush, b_clr} = '0; b_din = '0;
    {c_wr, c_rd, c_flush, c_clr} = '0; c_din = '0;
    exp_d = '0;
    wcount = 0;
    tick; tick;
    n_rst = 1'b1;
    tick;

    // 1: reset state and a short write/read burst
    chk("rst_empty", a_empty, 1);
    chk("rst_ae", a_ae, 1);
    chk("rst_count", a_count, 0);
    chk("rst_dout", a_dout, 8'h00);
    chk("rst_full", a_full, 0);
    chk("rst_af", a_af, 0);
    a_wr = 1; a_din = 8'hAA; tick;
    a_din = 8'hBB; tick;
    a_din = 8'hCC; tick;
    a_wr = 0;
    chk("t1_count3", a_count, 3);
    a_rd = 1; tick;
    chk("t1_rd0", a_dout, 8'hAA);
    tick;
    chk("t1_rd1", a_dout, 8'hBB);
    tick;
    chk("t1_rd2", a_dout, 8'hCC);
    a_rd = 0;
    chk("t1_empty", a_empty, 1);

    // 2: fill and watch threshold flags, then overflow
    for (int i = 0; i < 16; i++) begin
      a_wr = 1; a_din = 8'(i); tick;
      chk("t2_count", a_count, i + 1);
      chk("t2_ae", a_ae, (i + 1 <= 2) ? 1 : 0);
      chk("t2_af", a_af, (i + 1 >= 14) ? 1 : 0);
      chk("t2_full", a_full, (i + 1 == 16) ? 1 : 0);
    end
    a_din = 8'hFF; tick;
    a_wr = 0;
    chk("t2_ovf_count", a_count, 16);
    chk("t2_ovf", a_ovf, 1);
    a_rd = 1; tick;
    a_rd = 0;
    chk("t2_head", a_dout, 8'h00);
    chk("t2_count15", a_count, 15);
    a_clr = 1; tick;
    a_clr = 0;
    chk("t2_clr", a_ovf, 0);
    a_rd = 1;
    for (int i = 1; i < 16; i++) begin
      tick;
      chk("t2_drain", a_dout, 8'(i));
    end
    a_rd = 0;
    chk("t2_drained", a_count, 0);

    // 3: underflow, then simultaneous write/read at empty
    a_rd = 1; tick;
    chk("t3_count", a_count, 0);
    chk("t3_dout_hold", a_dout, 8'h0F);
    chk("t3_unf", a_unf, 1);
    a_wr = 1; a_din = 8'h5A; tick;
    a_wr = 0; a_rd = 0;
    chk("t3_both_count", a_count, 1);
    chk("t3_unf_sticky", a_unf, 1);
    chk("t3_dout_hold2", a_dout, 8'h0F);
    a_rd = 1; a_clr = 1; tick;
    a_rd = 0; a_clr = 0;
    chk("t3_pop", a_dout, 8'h5A);
    chk("t3_unf_clr", a_unf, 0);

    // 4: steady-state simultaneous traffic, then both at full
    a_wr = 1;
    for (int i = 0; i < 5; i++) begin
      a_din = 8'(8'h10 + i); tick;
    end
    chk("t4_pre", a_count, 5);
    a_rd = 1;
    for (int i = 0; i < 20; i++) begin
      a_din = 8'(8'h20 + i); tick;
      chk("t4_count", a_count, 5);
      chk("t4_data", a_dout, (i < 5) ? 8'(8'h10 + i) : 8'(8'h20 + i - 5));
    end
    a_rd = 0;
    for (int i = 0; i < 11; i++) begin
      a_din = 8'(8'h40 + i); tick;
    end
    chk("t4_full", a_full, 1);
    a_rd = 1; a_din = 8'hEE; tick;
    a_wr = 0;
    chk("t4_both_full_count", a_count, 15);
    chk("t4_both_full_dout", a_dout, 8'h2F);
    chk("t4_both_full_ovf", a_ovf, 1);
    for (int i = 0; i < 15; i++) begin
      tick;
      chk("t4_drain", a_dout, (i < 4) ? 8'(8'h30 + i) : 8'(8'h40 + i - 4));
    end
    a_rd = 0;
    chk("t4_empty", a_count, 0);

    // 5: depth-12 random streaming against a queue model
    for (int it = 0; it < 2000 && (wcount < 40 || q.size() > 0); it++) begin
      b_wr = (wcount < 40) && ($urandom_range(0, 3) != 0);
      b_rd = ($urandom_range(0, 1) == 1);
      b_din = 8'(8'h80 + wcount);
      exp_wr = b_wr && (q.size() < 12);
      exp_rd = b_rd && (q.size() > 0);
      if (exp_rd) exp_d = q.pop_front();
      if (exp_wr) begin
        q.push_back(b_din);
        wcount++;
      end
      tick;
      if (exp_rd) chk("t5_data", b_dout, exp_d);
      chk("t5_count", b_count, q.size());
      chk("t5_count_max", (b_count <= 5'd12) ? 1 : 0, 1);
    end
    b_wr = 0; b_rd = 0;
    chk("t5_all_written", wcount, 40);
    chk("t5_drained", b_empty, 1);
    b_clr = 1; tick;
    b_clr = 0;
    chk("t5_ovf_clr", b_ovf, 0);
    chk("t5_unf_clr", b_unf, 0);
    b_wr = 1;
    for (int i = 0; i < 7; i++) begin
      b_din = 8'(8'h60 + i); tick;
    end
    chk("t5_count7", b_count, 7);
    b_flush = 1; b_din = 8'hEE; tick;
    b_flush = 0; b_wr = 0;
    chk("t5_flush_count", b_count, 0);
    chk("t5_flush_empty", b_empty, 1);
    chk("t5_flush_ovf", b_ovf, 0);
    chk("t5_flush_unf", b_unf, 0);
    chk("t5_flush_dout", b_dout, 8'h00);
    b_wr = 1; b_din = 8'h77; tick;
    b_wr = 0; b_rd = 1; tick;
    b_rd = 0;
    chk("t5_after_flush", b_dout, 8'h77);
    chk("t5_after_flush_count", b_count, 0);

    // 6: first-word-fall-through, then asynchronous reset mid-stream
    chk("t6_idle_dout", c_dout, 8'h00);
    c_wr = 1; c_din = 8'hAA; tick;
    c_wr = 0;
    chk("t6_empty", c_empty, 0);
    chk("t6_fwft", c_dout, 8'hAA);
    c_rd = 1; tick;
    c_rd = 0;
    chk("t6_pop_dout", c_dout, 8'h00);
    chk("t6_pop_empty", c_empty, 1);
    c_wr = 1; c_din = 8'h11; tick;
    c_din = 8'h22; tick;
    chk("t6_head", c_dout, 8'h11);
    chk("t6_count2", c_count, 2);
    c_din = 8'h33;
    n_rst = 1'b0;
    #1;
    chk("t6_rst_count", c_count, 0);
    chk("t6_rst_empty", c_empty, 1);
    chk("t6_rst_dout", c_dout, 8'h00);
    chk("t6_rst_ae", c_ae, 1);
    chk("t6_rst_full", c_full, 0);
    chk("t6_rst_a_dout", a_dout, 8'h00);
    chk("t6_rst_a_ovf", a_ovf, 0);
    c_wr = 0;
    tick;
    chk("t6_rst_hold", c_count, 0);
    n_rst = 1'b1;
    tick;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_sync_prog.md
Name: fifo_sync_prog

Overview:
Parametrised successor to the team's single-clock synchronous FIFO. Adds non-power-of-two depth, programmable almost-full/almost-empty thresholds, an occupancy count, sticky overflow/underflow error flags, a synchronous flush, and an optional first-word-fall-through (FWFT) read mode. It sits between producer and consumer logic in one clock domain.

Parameters:
DATA_WIDTH, 8, width of data word.
ADDR_WIDTH, 4, pointer width; requires 2 <= DEPTH <= 2**ADDR_WIDTH.
DEPTH, 16, number of storage entries; need not be a power of two.
AF_LEVEL, DEPTH-2, f_almost_full asserts when count >= AF_LEVEL.
AE_LEVEL, 2, f_almost_empty asserts when count <= AE_LEVEL.
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through.

Ports:
clk  in  1  rising-edge clock.
n_rst  in  1  asynchronous, active-low reset.
wr_en  in  1  write request.
rd_en  in  1  read request.
flush  in  1  synchronous empty-the-FIFO command.
clr_err  in  1  clears sticky error flags.
din  in  DATA_WIDTH  write data.
dout  out  DATA_WIDTH  read data.
f_full  out  1  count == DEPTH.
f_empty  out  1  count == 0.
f_almost_full  out  1  count >= AF_LEVEL.
f_almost_empty  out  1  count <= AE_LEVEL.
count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
f_overflow  out  1  sticky: a write was rejected.
f_underflow  out  1  sticky: a read was rejected.

Behaviour:
- Reset (n_rst=0, asynchronous): wr_ptr=rd_ptr=0, count=0, dout=0, f_overflow=f_underflow=0, so f_empty=1, f_almost_empty=1, f_full=0, f_almost_full=0. Memory contents are not reset.
- All flags are decoded from the registered count. No combinational path runs from wr_en/rd_en to any flag.
- Write accepted iff wr_en && !f_full. On acceptance, mem[wr_ptr]<=din and wr_ptr advances.
- Read accepted iff rd_en && !f_empty. On acceptance, rd_ptr advances.
- Pointer wrap: DEPTH-1 -> 0, explicit compare, no power-of-two masking.
- count next value:
  - +1 on write only.
  - -1 on read only.
  - Unchanged when both are accepted or neither is.
- Simultaneous wr_en and rd_en:
  - When full: only the read is accepted; count goes to DEPTH-1 and f_overflow is set.
  - When empty: only the write is accepted; count goes to 1 and f_underflow is set.
  - Otherwise: both are accepted; count is unchanged and order is preserved.
- FWFT=0: dout is registered and loads mem[rd_ptr] at the edge where a read is accepted, so data is visible the cycle after rd_en is sampled. dout holds its value on any cycle without an accepted read, including rejected reads.
- FWFT=1: dout = f_empty ? 0 : mem[rd_ptr], decoded from registered state. The head word is visible the cycle after its write is accepted into an empty FIFO. Asserting rd_en pops the head, and the next word (if any) appears the following cycle.
- f_overflow is set on wr_en && f_full. f_underflow is set on rd_en && f_empty.
- Both error flags clear on clr_err. If set and clear occur in the same cycle, set wins.
- flush (synchronous) has priority over wr_en and rd_en:
  - pointers and count go to 0; FWFT=0 dout goes to 0.
  - wr_en and rd_en in that cycle are ignored and set no error flags.
  - error flags are unaffected by flush.
- Reset mid-operation aborts everything immediately. The FIFO returns to its reset state, and the data in flight is lost.

Test Plan:
1. Use DEPTH=16, FWFT=0. Reset, then release. Required: f_empty=1, f_almost_empty=1, count=0, dout=0x00, f_full=0. Write 0xAA, 0xBB, 0xCC, then read 3 times. Required: dout=0xAA, 0xBB, 0xCC, each on the cycle after its read; then f_empty=1.
2. Fill with 0x00..0x0F. Required: f_almost_empty deasserts at count=3, f_almost_full asserts at count=14, f_full at count=16. Write 0xFF. Required: count stays 16, f_overflow=1. Next read returns 0x00. Pulse clr_err. Required: f_overflow=0.
3. Read at empty. Required: count=0, dout unchanged, f_underflow=1. Then assert wr_en and rd_en together at empty with din=0x5A. Required: count=1, f_underflow stays 1.
4. Preload 5 entries, then do 20 cycles of simultaneous write/read with an incrementing pattern. Required: count stays 5 and the output sequence matches input order. At full, assert both. Required: count=15 and the write is rejected.
5. Use DEPTH=12, ADDR_WIDTH=4. Stream 40 words with random wr_en/rd_en. Required: pointers wrap 11->0, no data loss or reordering versus a scoreboard, count never exceeds 12. Assert flush at count=7 with wr_en=1. Required: count=0, f_empty=1, no error flags set.
6. Use FWFT=1. Write 0xAA into empty. Required: next cycle f_empty=0 and dout=0xAA with no read issued. Read. Required: dout=0x00 next cycle. Assert n_rst low mid-stream. Required: all outputs return to reset values immediately.
